hazard_stall_unit: RTL and testbench

//   Writer-side companion to the forwarding logic. It tracks the destination tags (rd, RegWrite, MemRead) of
//   in-flight instructions through the ID/EX -> EX/MEM -> MEM/WB stages. It detects load-use hazards that

---
 rtl/hazard_stall_unit.sv | 104 ++++++++++
 tb/tb_hazard_stall_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// Load-use hazard detector: carries destination tags through ID/EX, EX/MEM and MEM/WB,
// stalls PC/IF-ID and bubbles ID/EX when a load result cannot be forwarded in time.
module hazard_stall_unit #(
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             flush,
  input  logic             cnt_clr,
  output logic             stall,
  output logic             idex_bubble,
  output logic [REG_W-1:0] idex_rd,
  output logic             idex_memread,
  output logic [REG_W-1:0] exmem_rd,
  output logic             exmem_regwrite,
  output logic [REG_W-1:0] memwb_rd,
  output logic             memwb_regwrite,
  output logic [CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             memread;
  } tag_t;

  localparam logic LAT2 = 1'(LOAD_LAT == 2);

  tag_t             r_idex;
  tag_t             r_exmem;
  logic [REG_W-1:0] r_memwb_rd;
  logic             r_memwb_regwrite;
  logic [CNT_W-1:0] r_count;

  tag_t w_id_tag;
  logic w_match_idex;
  logic w_match_exmem;
  logic w_haz;

  // A stage blocks ID only if it holds a load writing a nonzero register that ID reads.
  function automatic logic tag_match(input tag_t             t,
                                     input logic             v,
                                     input logic [REG_W-1:0] rs,
                                     input logic [REG_W-1:0] rt,
                                     input logic             uses_rt);
    return t.memread & t.regwrite & (t.rd != '0) & v &
           ((t.rd == rs) | (uses_rt & (t.rd == rt)));
  endfunction

  assign w_match_idex  = tag_match(r_idex,  id_valid, id_rs, id_rt, id_uses_rt);
  assign w_match_exmem = tag_match(r_exmem, id_valid, id_rs, id_rt, id_uses_rt);

  // With a two-stage load, the EX/MEM copy of the load is still too early to forward.
  assign w_haz       = w_match_idex | (LAT2 & w_match_exmem);
  assign stall       = w_haz & ~flush;
  assign idex_bubble = stall | flush;

  assign w_id_tag.rd       = id_rd;
  assign w_id_tag.regwrite = id_regwrite & id_valid;
  assign w_id_tag.memread  = id_memread & id_valid;

  // NOTE: non-blocking assignments so every stage captures its predecessor's pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idex           <= '0;
      r_exmem          <= '0;
      r_memwb_rd       <= '0;
      r_memwb_regwrite <= 1'b0;
    end else begin
      r_idex           <= idex_bubble ? '0 : w_id_tag;
      r_exmem          <= r_idex;
      r_memwb_rd       <= r_exmem.rd;
      r_memwb_regwrite <= r_exmem.regwrite;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (cnt_clr) begin
      r_count <= '0;
    end else if (stall && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign idex_rd        = r_idex.rd;
  assign idex_memread   = r_idex.memread;
  assign exmem_rd       = r_exmem.rd;
  assign exmem_regwrite = r_exmem.regwrite;
  assign memwb_rd       = r_memwb_rd;
  assign memwb_regwrite = r_memwb_regwrite;
  assign stall_count    = r_count;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench: directed instruction vectors push hand-computed expectations,
// a negedge monitor pops and compares against the selected DUT instance.
module tb_hazard_stall_unit;

  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       ur;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } ins_t;

  typedef struct packed {
    logic        stall;
    logic        bubble;
    logic [4:0]  idex_rd;
    logic        idex_mr;
    logic [4:0]  exmem_rd;
    logic        exmem_rw;
    logic [4:0]  memwb_rd;
    logic        memwb_rw;
    logic [15:0] cnt;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       id_valid, id_uses_rt, id_regwrite, id_memread, flush, cnt_clr;
  logic [4:0] id_rs, id_rt, id_rd;

  logic [2:0]       stall_w, bubble_w, idex_mr_w, exmem_rw_w, memwb_rw_w;
  logic [2:0][4:0]  idex_rd_w, exmem_rd_w, memwb_rd_w;
  logic [2:0][15:0] cnt_w;

  // Instance 0: LOAD_LAT=1; instance 1: LOAD_LAT=2; instance 2: LOAD_LAT=2 with a narrow counter.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LL = (g == 0) ? 1 : 2;
    localparam int CW = (g == 2) ? 8 : 16;
    logic [CW-1:0] cnt;
    hazard_stall_unit #(.REG_W(5), .LOAD_LAT(LL), .CNT_W(CW)) u_dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rt(id_uses_rt), .id_rd(id_rd), .id_regwrite(id_regwrite),
      .id_memread(id_memread), .flush(flush), .cnt_clr(cnt_clr),
      .stall(stall_w[g]), .idex_bubble(bubble_w[g]), .idex_rd(idex_rd_w[g]),
      .idex_memread(idex_mr_w[g]), .exmem_rd(exmem_rd_w[g]),
      .exmem_regwrite(exmem_rw_w[g]), .memwb_rd(memwb_rd_w[g]),
      .memwb_regwrite(memwb_rw_w[g]), .stall_count(cnt)
    );
    assign cnt_w[g] = 16'(cnt);
  end

  string name_q[$];
  int    sel_q[$];
  obs_t  obs_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  function automatic ins_t ins_op(input int rd, input int rs, input int rt, input int ur,
                                  input int rw, input int mr);
    ins_t i;
    i.v  = 1'b1;
    i.rs = 5'(rs);
    i.rt = 5'(rt);
    i.ur = 1'(ur);
    i.rd = 5'(rd);
    i.rw = 1'(rw);
    i.mr = 1'(mr);
    return i;
  endfunction

  function automatic ins_t ins_lw(input int rd);
    return ins_op(rd, 2, 0, 0, 1, 1);
  endfunction

  function automatic ins_t ins_add(input int rd, input int rs, input int rt);
    return ins_op(rd, rs, rt, 1, 1, 0);
  endfunction

  function automatic ins_t ins_sw(input int rs, input int rt);
    return ins_op(0, rs, rt, 1, 0, 0);
  endfunction

  function automatic ins_t ins_nop();
    return '0;
  endfunction

  function automatic obs_t ob(input int st, input int bb, input int ird, input int imr,
                              input int erd, input int erw, input int mrd, input int mrw,
                              input int cnt);
    obs_t o;
    o.stall    = 1'(st);
    o.bubble   = 1'(bb);
    o.idex_rd  = 5'(ird);
    o.idex_mr  = 1'(imr);
    o.exmem_rd = 5'(erd);
    o.exmem_rw = 1'(erw);
    o.memwb_rd = 5'(mrd);
    o.memwb_rw = 1'(mrw);
    o.cnt      = 16'(cnt);
    return o;
  endfunction

  function automatic string obs2s(input obs_t o);
    return $sformatf("stall=%0d bubble=%0d idex=%0d/%0d exmem=%0d/%0d memwb=%0d/%0d cnt=%0d",
                     o.stall, o.bubble, o.idex_rd, o.idex_mr, o.exmem_rd, o.exmem_rw,
                     o.memwb_rd, o.memwb_rw, o.cnt);
  endfunction

  task automatic drive(input ins_t i, input logic fl, input logic clr);
    id_valid    = i.v;
    id_rs       = i.rs;
    id_rt       = i.rt;
    id_uses_rt  = i.ur;
    id_rd       = i.rd;
    id_regwrite = i.rw;
    id_memread  = i.mr;
    flush       = fl;
    cnt_clr     = clr;
  endtask

  // One ID cycle: apply inputs just after the edge, record what this cycle must show.
  task automatic vec(input string nm, input int sel, input ins_t i, input logic fl,
                     input logic clr, input obs_t e);
    drive(i, fl, clr);
    name_q.push_back(nm);
    sel_q.push_back(sel);
    obs_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(ins_nop(), 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: compare on the falling edge, away from the sampling edge.
  initial begin
    string nm;
    int    s;
    obs_t  e;
    obs_t  a;
    forever begin
      @(negedge clk);
      if (obs_q.size() > 0) begin
        nm = name_q.pop_front();
        s  = sel_q.pop_front();
        e  = obs_q.pop_front();
        a.stall    = stall_w[s];
        a.bubble   = bubble_w[s];
        a.idex_rd  = idex_rd_w[s];
        a.idex_mr  = idex_mr_w[s];
        a.exmem_rd = exmem_rd_w[s];
        a.exmem_rw = exmem_rw_w[s];
        a.memwb_rd = memwb_rd_w[s];
        a.memwb_rw = memwb_rw_w[s];
        a.cnt      = cnt_w[s];
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL %s (dut%0d): got %s | expected %s", nm, s, obs2s(a), obs2s(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_cnt;
    int r;
    rst_n = 1'b0;
    drive(ins_nop(), 1'b0, 1'b0);
    @(posedge clk);
    #1;
    vec("reset_state", 0, ins_lw(8), 1'b0, 1'b0, ob(0,0, 0,0, 0,0, 0,0, 0));
    rst_n = 1'b1;

    // Load-use, single-stage load latency.
    do_reset();
    vec("t1_lw",      0, ins_lw(8),        1'b0, 1'b0, ob(0,0, 0,0, 0,0, 0,0, 0));
    vec("t1_stall",   0, ins_add(9, 8, 1), 1'b0, 1'b0, ob(1,1, 8,1, 0,0, 0,0, 0));
    vec("t1_release", 0, ins_add(9, 8, 1), 1'b0, 1'b0, ob(0,0, 0,0, 8,1, 0,0, 1));
    vec("t1_add_ex",  0, ins_nop(),        1'b0, 1'b0, ob(0,0, 9,0, 0,0, 8,1, 1));
    vec("t1_drain",   0, ins_nop(),        1'b0, 1'b0, ob(0,0, 0,0, 9,1, 0,0, 1));

    // Two-stage load latency: back-to-back, then one instruction apart with a clear.
    do_reset();
    vec("t2_lw",       1, ins_lw(8),        1'b0, 1'b0, ob(0,0, 0,0, 0,0, 0,0, 0));
    vec("t2_stall1",   1, ins_add(9, 8, 1), 1'b0, 1'b0, ob(1,1, 8,1, 0,0, 0,0, 0));
    vec("t2_stall2",   1, ins_add(9, 8, 1), 1'b0, 1'b0, ob(1,1, 0,0, 8,1, 0,0, 1));
    vec("t2_release",  1, ins_add(9, 8, 1), 1'b0, 1'b0, ob(0,0, 0,0, 0,0, 8,1, 2));
    vec("t2_add_ex",   1, ins_nop(),        1'b0, 1'b0, ob(0,0, 9,0, 0,0, 0,0, 2));
    vec("t2_lw_b",     1, ins_lw(8),        1'b0, 1'b0, ob(0,0, 0,0, 9,1, 0,0, 2));
    vec("t2_gap",      1, ins_nop(),        1'b0, 1'b0, ob(0,0, 8,1, 0,0, 9,1, 2));
    vec("t2_gap_stl",  1, ins_add(9, 8, 1), 1'b0, 1'b1, ob(1,1, 0,0, 8,1, 0,0, 2));
    vec("t2_clr_prio", 1, ins_add(9, 8, 1), 1'b0, 1'b0, ob(0,0, 0,0, 0,0, 8,1, 0));
    vec("t2_gap_end",  1, ins_nop(),        1'b0, 1'b0, ob(0,0, 9,0, 0,0, 0,0, 0));

    // Register 0 never stalls.
    do_reset();
    vec("t3_lw_r0",  0, ins_lw(0),        1'b0, 1'b0, ob(0,0, 0,0, 0,0, 0,0, 0));
    vec("t3_use_r0", 0, ins_add(9, 0, 0), 1'b0, 1'b0, ob(0,0, 0,1, 0,0, 0,0, 0));
    vec("t3_after",  0, ins_nop(),        1'b0, 1'b0, ob(0,0, 9,0, 0,1, 0,0, 0));

    // rt dependency honoured only when the instruction reads rt; rs==rt gives one stall.
    do_reset();
    vec("t4_lw5",      0, ins_lw(5),                 1'b0, 1'b0, ob(0,0, 0,0, 0,0, 0,0, 0));
    vec("t4_sw_rt",    0, ins_sw(2, 5),              1'b0, 1'b0, ob(1,1, 5,1, 0,0, 0,0, 0));
    vec("t4_sw_go",    0, ins_sw(2, 5),              1'b0, 1'b0, ob(0,0, 0,0, 5,1, 0,0, 1));
    vec("t4_lw5_b",    0, ins_lw(5),                 1'b0, 1'b0, ob(0,0, 0,0, 0,0, 5,1, 1));
    vec("t4_no_rt",    0, ins_op(7, 3, 5, 0, 1, 0), 1'b0, 1'b0, ob(0,0, 5,1, 0,0, 0,0, 1));
    vec("t4_no_rt_ex", 0, ins_nop(),                 1'b0, 1'b0, ob(0,0, 7,0, 5,1, 0,0, 1));
    vec("t4_lw6",      0, ins_lw(6),                 1'b0, 1'b0, ob(0,0, 0,0, 7,1, 5,1, 1));
    vec("t4_dbl_stl",  0, ins_add(10, 6, 6),         1'b0, 1'b0, ob(1,1, 6,1, 0,0, 7,1, 1));
    vec("t4_dbl_go",   0, ins_add(10, 6, 6),         1'b0, 1'b0, ob(0,0, 0,0, 6,1, 0,0, 2));
    vec("t4_dbl_end",  0, ins_nop(),                 1'b0, 1'b0, ob(0,0, 10,0, 0,0, 6,1, 2));

    // Flush overrides the stall and zeroes the next ID/EX tag.
    do_reset();
    vec("t5_lw",    0, ins_lw(8),        1'b0, 1'b0, ob(0,0, 0,0, 0,0, 0,0, 0));
    vec("t5_flush", 0, ins_add(9, 8, 1), 1'b1, 1'b0, ob(0,1, 8,1, 0,0, 0,0, 0));
    vec("t5_after", 0, ins_nop(),        1'b0, 1'b0, ob(0,0, 0,0, 8,1, 0,0, 0));

    // Counter saturation on the 8-bit instance: repeating lw, add(stall), add(stall).
    do_reset();
    for (int t = 0; t < 405; t++) begin
      r       = t % 3;
      exp_cnt = 2 * (t / 3) + ((r == 2) ? 1 : 0);
      if (exp_cnt > 255) exp_cnt = 255;
      vec("t6_sat", 2, (r == 0) ? ins_lw(8) : ins_add(9, 8, 1), 1'b0, 1'b0,
          ob((r != 0) ? 1 : 0, (r != 0) ? 1 : 0,
             (r == 1) ? 8 : 0, (r == 1) ? 1 : 0,
             (r == 2) ? 8 : 0, (r == 2) ? 1 : 0,
             (r == 0 && t >= 3) ? 8 : 0, (r == 0 && t >= 3) ? 1 : 0,
             exp_cnt));
    end
    vec("t6_clr",     2, ins_nop(), 1'b0, 1'b1, ob(0,0, 0,0, 0,0, 8,1, 255));
    vec("t6_cleared", 2, ins_nop(), 1'b0, 1'b0, ob(0,0, 0,0, 0,0, 0,0, 0));

    // Reset asserted in the middle of a two-cycle stall.
    do_reset();
    vec("t7_lw",    1, ins_lw(8),        1'b0, 1'b0, ob(0,0, 0,0, 0,0, 0,0, 0));
    vec("t7_stall", 1, ins_add(9, 8, 1), 1'b0, 1'b0, ob(1,1, 8,1, 0,0, 0,0, 0));
    rst_n = 1'b0;
    vec("t7_async_rst", 1, ins_add(9, 8, 1), 1'b0, 1'b0, ob(0,0, 0,0, 0,0, 0,0, 0));
    rst_n = 1'b1;
    vec("t7_restart", 1, ins_add(9, 8, 1), 1'b0, 1'b0, ob(0,0, 0,0, 0,0, 0,0, 0));
    vec("t7_flow",    1, ins_nop(),        1'b0, 1'b0, ob(0,0, 9,0, 0,0, 0,0, 0));

    repeat (3) @(posedge clk);
    if (obs_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", obs_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
